mem_arbiter: RTL and testbench

- Shares the single-ported 16-bit-address, 32-bit-data memory between three requesters: instruction fetch (IF, read-only), datapath load/store (LS), and the external program loader/debug port (LD).
- Sits between the datapath's memory-address path and the memory macro, and replaces direct IMem/DMem wiring.
- Performs fixed-priority arbitration with starvation protection, a loader bus lock, a variable-latency memory handshake, and a timeout.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/arb_picker.sv | 43 ++++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, requester ids,
// the data word returned on a timed-out access, and a one-hot helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0]  ID_IF    = 2'd0;
    localparam logic [1:0]  ID_LS    = 2'd1;
    localparam logic [1:0]  ID_LD    = 2'd2;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    // Requester id to the one-hot bit position used by gnt/rvalid.
    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        logic [2:0] oh;
        oh = 3'b000;
        case (id)
            ID_IF:   oh = 3'b001;
            ID_LS:   oh = 3'b010;
            ID_LD:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: loader lock first, then the starvation
// override for instruction fetch, then fixed priority LD > LS > IF.
module arb_picker
    import mem_arb_pkg::*;
(
    input  logic       en,          // arbitration window (IDLE, out of reset)
    input  logic       ld_lock,
    input  logic       starve_hit,  // fetch has been denied long enough
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       ld_req,
    output logic [2:0] gnt,
    output logic [1:0] win_id
);

    // Pick at most one requester; gnt stays zero outside the window.
    always_comb begin
        gnt    = 3'b000;
        win_id = ID_IF;
        if (en) begin
            if (ld_lock) begin
                // Lock excludes IF/LS entirely, even if LD is not asking.
                if (ld_req) begin
                    gnt    = 3'b100;
                    win_id = ID_LD;
                end
            end else if (starve_hit && if_req) begin
                gnt    = 3'b001;
                win_id = ID_IF;
            end else if (ld_req) begin
                gnt    = 3'b100;
                win_id = ID_LD;
            end else if (ls_req) begin
                gnt    = 3'b010;
                win_id = ID_LS;
            end else if (if_req) begin
                gnt    = 3'b001;
                win_id = ID_IF;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of a single-ported memory. One access at a
// time: IDLE grants, ACCESS drives the memory until ready or timeout, RESP
// returns a one-cycle completion pulse to the winner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_lock,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state_q,   state_d;
    logic [SW-1:0]         starve_q,  starve_d;
    logic [TW-1:0]         tmo_q,     tmo_d;
    logic [1:0]            id_q,      id_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  err_q,     err_d;

    logic [2:0]            pick_gnt;
    logic [1:0]            pick_id;
    logic                  arb_en;
    logic                  starve_hit;
    logic                  in_access;

    assign arb_en     = (state_q == IDLE) && reset;
    assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
    assign in_access  = (state_q == ACCESS);

    arb_picker u_picker (
        .en         (arb_en),
        .ld_lock    (ld_lock),
        .starve_hit (starve_hit),
        .if_req     (if_req),
        .ls_req     (ls_req),
        .ld_req     (ld_req),
        .gnt        (pick_gnt),
        .win_id     (pick_id)
    );

    // Next-state logic: grant latching, memory handshake, timeout, response.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // Fetch starvation tracking only advances while arbitrating.
                if (if_req && !pick_gnt[0]) begin
                    if (!starve_hit) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else begin
                    starve_d = '0;
                end

                if (pick_gnt != 3'b000) begin
                    state_d = ACCESS;
                    id_d    = pick_id;
                    tmo_d   = '0;
                    case (pick_id)
                        ID_LD: begin
                            we_d    = ld_we;
                            addr_d  = ld_addr;
                            wdata_d = ld_wdata;
                        end
                        ID_LS: begin
                            we_d    = ls_we;
                            addr_d  = ls_addr;
                            wdata_d = ls_wdata;
                        end
                        default: begin
                            // Fetch is read-only.
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = '0;
                        end
                    endcase
                end
            end

            ACCESS: begin
                // Ready wins over a coincident timeout.
                if (mem_ready) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rdata_d = DATA_WIDTH'(ERR_DATA);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            RESP: begin
                // rdata keeps its value; only the error flag is one-shot.
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
            id_q     <= ID_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign gnt       = pick_gnt;
    assign rvalid    = (state_q == RESP) ? id_to_onehot(id_q) : 3'b000;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign mem_req   = in_access;
    assign mem_we    = in_access & we_q;
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory (programmable
// ready delay) and a scoreboard of expected completions built at grant time.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        ls_req, ls_we;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ld_req, ld_we;
    logic [15:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        bus_err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ready_delay = 0;   // <0: memory never answers
    int acc_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return 32'hC0DE0000 | {24'h0, a};
    endfunction

    // Behavioural memory: unwritten words read as init_val(address).
    logic [31:0] mem    [0:255];
    bit          mem_wr [0:255];
    assign mem_ready = mem_req && (ready_delay >= 0) && (acc_cnt == ready_delay);
    assign mem_rdata = mem_wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[7:0]]    <= mem_wdata;
            mem_wr[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_req && !mem_ready) acc_cnt <= acc_cnt + 1;
        else                       acc_cnt <= 0;
    end

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] exp_mem [0:255];
    bit          exp_wr  [0:255];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on grant, pop and compare on completion.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (gnt != 3'b000) begin
                exp_t        e;
                logic        we;
                logic [15:0] a;
                logic [31:0] wd;
                if (gnt[2])      begin e.id = 2'd2; we = ld_we; a = ld_addr; wd = ld_wdata; end
                else if (gnt[1]) begin e.id = 2'd1; we = ls_we; a = ls_addr; wd = ls_wdata; end
                else             begin e.id = 2'd0; we = 1'b0;  a = if_addr; wd = 32'h0;    end
                if (ready_delay < 0 || ready_delay >= 16) begin
                    e.data = 32'hDEADBEEF; e.err = 1'b1;
                end else if (we) begin
                    e.data = 32'h0; e.err = 1'b0;
                    exp_mem[a[7:0]] = wd;
                    exp_wr[a[7:0]]  = 1'b1;
                end else begin
                    e.data = exp_wr[a[7:0]] ? exp_mem[a[7:0]] : init_val(a[7:0]);
                    e.err  = 1'b0;
                end
                sb.push_back(e);
            end
            if (rvalid != 3'b000) begin
                exp_t e;
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", {61'h0, rvalid}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    $display("resp id=%0d rdata=%h err=%0b", e.id, rdata, bus_err);
                    chk("resp", {28'h0, rvalid, rdata, bus_err},
                        {28'h0, 3'(1 << e.id), e.data, e.err});
                end
            end
        end
    end

    // Wait (bounded) for the next grant, require it to be requester k.
    task automatic wait_grant(input int k, input bit drop, output int gcyc);
        int n = 0;
        @(negedge clk);
        while (gnt == 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        $display("grant %b at cycle %0d (want bit %0d)", gnt, cyc, k);
        chk("grant", {61'h0, gnt}, {61'h0, 3'(1 << k)});
        gcyc = cyc;
        @(posedge clk); #1;
        if (drop) begin
            case (k)
                0: if_req = 1'b0;
                1: ls_req = 1'b0;
                default: ld_req = 1'b0;
            endcase
        end
    endtask

    // Count consecutive ACCESS cycles; returns at the following (RESP) negedge.
    task automatic count_access(output int n);
        n = 0;
        @(negedge clk);
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int g0, g1, g2, n;
        reset = 1'b0; ld_lock = 1'b0;
        if_req = 1'b1; if_addr = 16'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 16'h0; ls_wdata = 32'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 16'h0; ld_wdata = 32'h0;

        // Power-on reset: outputs quiet, gnt suppressed despite if_req.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {61'h0, gnt}, 64'h0);
        chk("rst_outs", {rvalid, mem_req, bus_err, rdata, mem_addr},
            {3'b0, 1'b0, 1'b0, 32'h0, 16'h0});
        @(posedge clk); #1;
        if_req = 1'b0; reset = 1'b1;

        // 1: reset in the middle of a stuck LS store.
        ready_delay = -1;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 32'hBAD00010;
        wait_grant(1, 1'b1, g0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; if_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_gnt", {61'h0, gnt}, 64'h0);
        chk("midrst_outs", {59'h0, rvalid, mem_req}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b1; if_req = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("postrst_outs", {59'h0, rvalid, mem_req}, 64'h0);
        chk("mem_untouched", {63'h0, mem_wr[8'h10]}, 64'h0);

        // 2: three simultaneous requests -> LD, LS, IF every 3 cycles.
        ready_delay = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0004;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0008; ld_wdata = 32'h12345678;
        wait_grant(2, 1'b1, g0);
        wait_grant(1, 1'b1, g1);
        wait_grant(0, 1'b1, g2);
        chk("period_ld_ls", 64'(g1 - g0), 64'd3);
        chk("period_ls_if", 64'(g2 - g1), 64'd3);
        repeat (4) @(posedge clk); #1;

        // 3: LS hogging; IF wins after 4 IDLE denials, twice in a row.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0008;
        if_req = 1'b1; if_addr = 16'h0044;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) wait_grant(1, 1'b0, g0);
            wait_grant(0, (r == 1), g0);
        end
        ls_req = 1'b0;
        repeat (4) @(posedge clk); #1;

        // 4: loader lock holds off IF/LS while LD toggles.
        ld_lock = 1'b1;
        if_req = 1'b1; if_addr = 16'h0048;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0030;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0030; ld_wdata = 32'h0BADF00D;
        wait_grant(2, 1'b1, g0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lock_gnt", {61'h0, gnt}, 64'h0);
        end
        @(posedge clk); #1;
        ld_req = 1'b1; ld_addr = 16'h0031; ld_wdata = 32'h31313131;
        wait_grant(2, 1'b1, g0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lock_gnt2", {61'h0, gnt}, 64'h0);
        end
        @(posedge clk); #1;
        ld_lock = 1'b0;
        wait_grant(0, 1'b1, g0);
        wait_grant(1, 1'b1, g0);
        repeat (4) @(posedge clk); #1;

        // 5: memory never ready -> timeout after 16 ACCESS cycles.
        ready_delay = -1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020;
        wait_grant(1, 1'b1, g0);
        count_access(n);
        chk("tmo_len", 64'(n), 64'd16);
        chk("tmo_resp", {rvalid, bus_err, rdata}, {3'b010, 1'b1, 32'hDEADBEEF});
        @(negedge clk);
        chk("tmo_after", {rvalid, bus_err, mem_req, rdata}, {3'b0, 1'b0, 1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;

        // 6: ready on the 16th ACCESS cycle -> normal completion.
        ready_delay = 15;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0024;
        wait_grant(1, 1'b1, g0);
        count_access(n);
        chk("late_len", 64'(n), 64'd16);
        chk("late_resp", {rvalid, bus_err, rdata}, {3'b010, 1'b0, init_val(8'h24)});

        repeat (4) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
